perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised bank of event counters that replaces the fixed instruction and cycle counters in the core's debug logic. Each channel accumulates a multi-bit per-cycle increment, for example retired instructions, stall cycles or cache misses per stage. A start/stop FSM gates counting, a one-cycle snapshot bank gives a consistent read, and a registered read port returns the frozen values. The block sits beside `mips_core`, which drives its event inputs from pipeline and hazard-control signals; a test harness or debug host reads it.

## Interface
- `NUM_CNT`, default 8: number of counter channels (1–32).
- `CNT_WIDTH`, default 32: width of each counter and snapshot register.
- `INC_WIDTH`, default 2: width of each per-channel increment (0 to 2^INC_WIDTH−1 per cycle).
- `SATURATE`, default 0: 0 = counters wrap modulo 2^CNT_WIDTH; 1 = counters hold at all-ones.
- Clock/reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_inc`  in  NUM_CNT*INC_WIDTH  per-channel increment; channel k occupies bits [k*INC_WIDTH +: INC_WIDTH].
- `i_start`  in  1  enter RUN.
- `i_stop`  in  1  enter HALT.
- `i_clear`  in  1  zero all live counters.
- `i_snapshot`  in  1  copy all live counters into the snapshot bank.
- `i_rd_req`  in  1  read request.
- `i_rd_idx`  in  $clog2(NUM_CNT) (minimum 1)  channel to read.
- `i_ovf_ack`  in  1  clear sticky overflow flags.
- `o_running`  out  1  high in RUN.
- `o_rd_valid`  out  1  read data valid.
- `o_rd_data`  out  CNT_WIDTH  snapshot value of the requested channel.
- `o_ovf_irq`  out  1  overflow interrupt.

## Operation
- FSM states: IDLE, RUN, HALT.
  - IDLE → RUN on `i_start`.
  - RUN → HALT on `i_stop`.
  - HALT → RUN on `i_start`.
  - `i_start` and `i_stop` in the same cycle: `i_stop` wins, so RUN goes to HALT and IDLE/HALT go to HALT.
- Counting happens only in RUN, evaluated on the state at the current edge: counter[k] += inc[k].
- Arithmetic is done at CNT_WIDTH+1 bits. A carry out of CNT_WIDTH is an overflow.
  - SATURATE=0: the counter keeps the low CNT_WIDTH bits (wraps).
  - SATURATE=1: the counter becomes all-ones.
- `i_clear` zeroes every live counter and overrides any increment in the same cycle. FSM state is unchanged. The snapshot bank is untouched.
- `i_snapshot` copies the pre-update live values, i.e. values before that cycle's increment or clear. Snapshot plus clear in the same cycle therefore gives read-and-reset semantics.
- Read port:
  - `i_rd_req` samples snapshot[i_rd_idx] at the request edge.
  - An index ≥ NUM_CNT returns 0, with `o_rd_valid` still asserted.
  - Back-to-back requests are accepted every cycle.
  - A read issued in the same cycle as `i_snapshot` returns the old snapshot value.

## Timing
- Reset values:
  - state = IDLE.
  - All counters, snapshots and overflow flags = 0.
  - `o_running`, `o_rd_valid`, `o_ovf_irq` = 0; `o_rd_data` = 0.
- `o_running` is registered and follows the state.
- Counter update, clear and snapshot take effect at the edge where the input is sampled high. The new value is visible one cycle later.
- Read latency is exactly 1 cycle:
  - `o_rd_valid` pulses for one cycle.
  - `o_rd_data` holds its last value when `o_rd_valid` is low.
- Reset asserted mid-operation returns everything to reset values immediately. An in-flight read is dropped and produces no `o_rd_valid`.

## Configuration
- `PERF_CNT_OVF_IRQ_EN` defined:
  - Each channel has a sticky overflow flag, set on any overflow event in either SATURATE mode.
  - `o_ovf_irq` is registered and equals OR of all flags.
  - `i_ovf_ack` clears all flags. If a new overflow occurs in the same cycle as the ack, the set wins.
  - `i_clear` does not clear the flags.
- `PERF_CNT_OVF_IRQ_EN` not defined:
  - No flag storage.
  - `o_ovf_irq` is tied to 0.
  - `i_ovf_ack` is ignored.

## Test plan
- Gating and read: reset, then hold `i_inc` ch0=1 for 10 cycles while IDLE, `i_start`, then 5 cycles of ch0=1, ch1=3, then `i_stop`, `i_snapshot`, read idx 0 and idx 1 → ch0=5, ch1=15. `o_rd_valid` is high exactly one cycle after each request.
- Wrap (CNT_WIDTH=8, SATURATE=0): preload to 254 via counting, then inc=3 → 1. With the macro defined, `o_ovf_irq`=1 one cycle later, and `i_ovf_ack` drops it to 0.
- Saturate (CNT_WIDTH=8, SATURATE=1): same stimulus → 255, holding at 255 under further increments, with the overflow flag set.
- Simultaneous events: in RUN with ch0=7 and inc=2, assert `i_snapshot` and `i_clear` together → snapshot reads 7 and live ch0=0 next cycle. With `i_start` and `i_stop` together from IDLE → state HALT and `o_running`=0.
- Out-of-range read (NUM_CNT=5): read idx 6 → `o_rd_data`=0 and `o_rd_valid`=1. Back-to-back reads of idx 0..4 return 5 consecutive valid beats.
- Reset mid-read: assert `rst_n`=0 in the cycle after `i_rd_req` → `o_rd_valid` stays 0, and all outputs go to reset values asynchronously.

Source files
------------

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: bank of NUM_CNT event counters with start/stop gating,
// a snapshot bank for consistent reads and a one-cycle registered read port.
// Optional build macro: PERF_CNT_OVF_IRQ_EN adds sticky per-channel overflow
// flags and a registered overflow interrupt; without it o_ovf_irq is tied low.
module perf_counter_bank #(
  parameter int NUM_CNT   = 8,
  parameter int CNT_WIDTH = 32,
  parameter int INC_WIDTH = 2,
  parameter int SATURATE  = 0,
  localparam int IDX_W    = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CNT*INC_WIDTH-1:0] i_inc,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic                         i_clear,
  input  logic                         i_snapshot,
  input  logic                         i_rd_req,
  input  logic [IDX_W-1:0]             i_rd_idx,
  input  logic                         i_ovf_ack,
  output logic                         o_running,
  output logic                         o_rd_valid,
  output logic [CNT_WIDTH-1:0]         o_rd_data,
  output logic                         o_ovf_irq
);

  localparam int SUM_W = CNT_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_running;
  logic                   w_count_en;
  logic [NUM_CNT-1:0]     w_ovf;
  logic [CNT_WIDTH-1:0]   w_snap [NUM_CNT];
  logic [CNT_WIDTH-1:0]   w_rd_val;
  logic                   r_rd_valid;
  logic [CNT_WIDTH-1:0]   r_rd_data;

  // State register and registered running flag (tracks the state being entered)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == ST_RUN);
    end
  end

  // Next-state logic: stop has priority over start
  always_comb begin
    w_state_nxt = r_state;
    if (i_stop) begin
      w_state_nxt = ST_HALT;
    end else if (i_start && (r_state != ST_RUN)) begin
      w_state_nxt = ST_RUN;
    end
  end

  assign w_count_en = (r_state == ST_RUN);
  assign o_running  = r_running;

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_ch
    logic [INC_WIDTH-1:0] w_inc;
    logic [SUM_W-1:0]     w_sum;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_snap;

    assign w_inc     = i_inc[k*INC_WIDTH +: INC_WIDTH];
    assign w_sum     = {1'b0, r_cnt} + SUM_W'(w_inc);
    // An overflow only counts when the increment is actually applied
    assign w_ovf[k]  = w_count_en && !i_clear && w_sum[CNT_WIDTH];
    assign w_snap[k] = r_snap;

    // Live counter: clear beats increment; carry either wraps or saturates
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (i_clear) begin
        r_cnt <= '0;
      end else if (w_count_en) begin
        if (w_sum[CNT_WIDTH] && (SATURATE != 0)) begin
          r_cnt <= '1;
        end else begin
          r_cnt <= w_sum[CNT_WIDTH-1:0];
        end
      end
    end

    // Snapshot captures the value before this cycle's update
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_snap <= '0;
      end else if (i_snapshot) begin
        r_snap <= r_cnt;
      end
    end
  end

  // Read mux: indices beyond the bank return zero
  always_comb begin
    w_rd_val = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (32'(i_rd_idx) == k) begin
        w_rd_val = w_snap[k];
      end
    end
  end

  // Registered read port: valid pulses one cycle after the request, data holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= i_rd_req;
      if (i_rd_req) begin
        r_rd_data <= w_rd_val;
      end
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;

`ifdef PERF_CNT_OVF_IRQ_EN
  logic [NUM_CNT-1:0] r_ovf_flag;
  logic [NUM_CNT-1:0] w_ovf_flag_nxt;
  logic               r_ovf_irq;

  // A new overflow in the same cycle as the ack keeps its flag set
  assign w_ovf_flag_nxt = (r_ovf_flag & {NUM_CNT{~i_ovf_ack}}) | w_ovf;

  // Sticky flags and the interrupt that reflects their OR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_flag <= '0;
      r_ovf_irq  <= 1'b0;
    end else begin
      r_ovf_flag <= w_ovf_flag_nxt;
      r_ovf_irq  <= |w_ovf_flag_nxt;
    end
  end

  assign o_ovf_irq = r_ovf_irq;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = ^{i_ovf_ack, w_ovf};
  assign o_ovf_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: a wrapping and a saturating
// instance (NUM_CNT=5, CNT_WIDTH=8) share stimulus; a reference model pushes
// expected read data into per-instance queues that are popped on o_rd_valid.
module tb_perf_counter_bank;
  localparam int N  = 5;
  localparam int CW = 8;
  localparam int IW = 2;
  localparam int MX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N*IW-1:0] inc;
  logic          start, stop, clr, snap, rd_req, ack;
  logic [2:0]    rd_idx;

  logic          run_w, vld_w, irq_w, run_s, vld_s, irq_s;
  logic [CW-1:0] dat_w, dat_s;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CNT(N), .CNT_WIDTH(CW), .INC_WIDTH(IW), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .i_inc(inc), .i_start(start), .i_stop(stop),
    .i_clear(clr), .i_snapshot(snap), .i_rd_req(rd_req), .i_rd_idx(rd_idx),
    .i_ovf_ack(ack), .o_running(run_w), .o_rd_valid(vld_w), .o_rd_data(dat_w),
    .o_ovf_irq(irq_w));

  perf_counter_bank #(.NUM_CNT(N), .CNT_WIDTH(CW), .INC_WIDTH(IW), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .i_inc(inc), .i_start(start), .i_stop(stop),
    .i_clear(clr), .i_snapshot(snap), .i_rd_req(rd_req), .i_rd_idx(rd_idx),
    .i_ovf_ack(ack), .o_running(run_s), .o_rd_valid(vld_s), .o_rd_data(dat_s),
    .o_ovf_irq(irq_s));

  int n_chk  = 0;
  int n_fail = 0;

  // reference model
  int     m_cnt_w [N];
  int     m_cnt_s [N];
  int     m_snap_w[N];
  int     m_snap_s[N];
  int     m_state;
  bit     m_run, m_vld, m_irq_w, m_irq_s;
  bit [N-1:0] m_flag_w, m_flag_s;
  int     m_last_w, m_last_s;
  int     q_w[$];
  int     q_s[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_cnt_w[k] = 0; m_cnt_s[k] = 0; m_snap_w[k] = 0; m_snap_s[k] = 0;
    end
    m_state = 0; m_run = 0; m_vld = 0; m_irq_w = 0; m_irq_s = 0;
    m_flag_w = '0; m_flag_s = '0; m_last_w = 0; m_last_s = 0;
    q_w.delete(); q_s.delete();
  endtask

  task automatic chk_all();
    check("running_w", run_w, m_run);
    check("running_s", run_s, m_run);
    check("rd_valid_w", vld_w, m_vld);
    check("rd_valid_s", vld_s, m_vld);
    if (m_vld) begin
      if (q_w.size() > 0) m_last_w = q_w.pop_front();
      if (q_s.size() > 0) m_last_s = q_s.pop_front();
    end
    check("rd_data_w", dat_w, m_last_w);
    check("rd_data_s", dat_s, m_last_s);
    check("ovf_irq_w", irq_w, m_irq_w);
    check("ovf_irq_s", irq_s, m_irq_s);
  endtask

  // advance one clock: model the edge from current inputs, then check outputs
  task automatic step();
    int nst, iv, sw, ss;
    bit [N-1:0] setw, sets;
    setw = '0; sets = '0;
    if (rd_req) begin
      q_w.push_back((int'(rd_idx) < N) ? m_snap_w[rd_idx] : 0);
      q_s.push_back((int'(rd_idx) < N) ? m_snap_s[rd_idx] : 0);
    end
    if (stop) nst = 2;
    else if (start && m_state != 1) nst = 1;
    else nst = m_state;
    for (int k = 0; k < N; k++) begin
      iv = int'(inc[k*IW +: IW]);
      if (snap) begin
        m_snap_w[k] = m_cnt_w[k];
        m_snap_s[k] = m_cnt_s[k];
      end
      if (clr) begin
        m_cnt_w[k] = 0; m_cnt_s[k] = 0;
      end else if (m_state == 1) begin
        sw = m_cnt_w[k] + iv;
        ss = m_cnt_s[k] + iv;
        if (sw > MX) begin setw[k] = 1'b1; sw = sw - (MX + 1); end
        if (ss > MX) begin sets[k] = 1'b1; ss = MX; end
        m_cnt_w[k] = sw; m_cnt_s[k] = ss;
      end
    end
`ifdef PERF_CNT_OVF_IRQ_EN
    m_flag_w = (ack ? '0 : m_flag_w) | setw;
    m_flag_s = (ack ? '0 : m_flag_s) | sets;
    m_irq_w  = |m_flag_w;
    m_irq_s  = |m_flag_s;
`endif
    m_state = nst;
    m_run   = (nst == 1);
    m_vld   = rd_req;
    @(posedge clk); #1;
    chk_all();
  endtask

  task automatic rd(input int idx);
    rd_req = 1'b1; rd_idx = 3'(idx);
    step();
    rd_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; inc = '0; start = 0; stop = 0; clr = 0; snap = 0;
    rd_req = 0; rd_idx = '0; ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    rst_n = 1'b1;

    // gating: counting ignored in IDLE, active in RUN
    inc[1:0] = 2'd1;
    repeat (10) step();
    inc = '0; start = 1; step(); start = 0;
    inc[1:0] = 2'd1; inc[3:2] = 2'd3;
    repeat (5) step();
    inc = '0; stop = 1; step(); stop = 0;
    snap = 1; step(); snap = 0;
    rd(0);
    check("gate_ch0", dat_w, 5);
    rd(1);
    check("gate_ch1", dat_s, 15);
    step();
    check("valid_pulse", vld_w, 0);

    // wrap / saturate on channel 2
    clr = 1; step(); clr = 0;
    start = 1; step(); start = 0;
    inc[5:4] = 2'd2;
    repeat (127) step();
    inc[5:4] = 2'd3; step();
    inc = '0; snap = 1; step(); snap = 0;
    rd(2);
    check("wrap_254p3", dat_w, 1);
    check("sat_254p3", dat_s, 255);
    inc[5:4] = 2'd3;
    repeat (3) step();
    inc = '0; snap = 1; step(); snap = 0;
    rd(2);
    check("wrap_more", dat_w, 10);
    check("sat_hold", dat_s, 255);
    ack = 1; step(); ack = 0;
    step();

    // simultaneous snapshot + clear, and read alongside snapshot
    clr = 1; step(); clr = 0;
    inc[1:0] = 2'd3; repeat (2) step();
    inc[1:0] = 2'd1; step();
    inc[1:0] = 2'd2; snap = 1; clr = 1; step(); snap = 0; clr = 0;
    inc = '0;
    rd_req = 1; rd_idx = 3'd0; snap = 1; step(); rd_req = 0; snap = 0;
    check("snap_clr_old", dat_w, 7);
    rd(0);
    check("snap_clr_new", dat_w, 0);

    // out-of-range and back-to-back reads
    inc = {N{2'd1}}; repeat (2) step();
    inc = '0; snap = 1; step(); snap = 0;
    rd(6);
    check("oor_data", dat_w, 0);
    check("oor_valid", vld_w, 1);
    for (int i = 0; i < N; i++) rd(i);
    rd(7);
    step();

    // reset during a read
    rd(1);
    rd_req = 1; rd_idx = 3'd2;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", vld_w, 0);
    check("rst_async_data", dat_w, 0);
    check("rst_async_run", run_s, 0);
    check("rst_async_irq", irq_s, 0);
    @(posedge clk); #1;
    check("rst_read_dropped", vld_w, 0);
    rd_req = 0;
    model_reset();
    rst_n = 1'b1;
    step();

    // start and stop together from IDLE land in HALT
    start = 1; stop = 1; step(); start = 0; stop = 0;
    check("start_stop_idle", run_w, 0);
    start = 1; step(); start = 0;
    rd(0);
    check("post_rst_snap", dat_s, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
